msrh_freelist_mp: RTL and testbench
===================================

// Module: msrh_freelist_mp
// PURPOSE
//  Multi-port circular free-ID list for rename/tag allocation. Up to PUSH_PORTS IDs are
//  returned and POP_PORTS IDs are allocated per cycle. Pops are all-or-nothing.
//  Tracks occupancy and flags overflow. Supports non-power-of-two depth.
//  A flush restores the full initial ID set in one cycle.
//  Sits between commit/release logic (push) and the rename/dispatch stage (pop).
// PARAMETERS
//  SIZE        32  number of entries (any value >= 2; need not be a power of two)
//  WIDTH        5  ID width in bits
//  INIT         0  first ID loaded at reset/flush; entry i holds INIT+i
//  PUSH_PORTS   2  release ports per cycle
//  POP_PORTS    2  allocation ports per cycle
// PORTS
//  i_clk          in   1                  clock
//  i_reset        in   1                  synchronous reset, active-high
//  i_flush        in   1                  restore initial full state (same effect as reset)
//  i_push_valid   in   PUSH_PORTS         per-port release strobe
//  i_push_id      in   PUSH_PORTS*WIDTH   ID being released on each port
//  i_pop_valid    in   POP_PORTS          per-port allocation request
//  o_pop_ready    out  1                  enough IDs to satisfy all asserted i_pop_valid
//  o_pop_id       out  POP_PORTS*WIDTH    ID offered to each pop port
//  o_count        out  $clog2(SIZE+1)     number of free IDs held
//  o_empty        out  1                  o_count == 0
//  o_full         out  1                  o_count == SIZE
//  o_overflow     out  1                  sticky error: push would exceed SIZE
// BEHAVIOUR
//  - Reset / flush (next edge): head=0, tail=0, count=SIZE, entry[i]=INIT+i, overflow=0.
//    Outputs after reset: o_count=SIZE, o_full=1, o_empty=0, o_pop_ready=1,
//    o_pop_id[p]=INIT+p, o_overflow=0.
//  - i_reset has priority over i_flush. i_flush has priority over push/pop in the same cycle;
//    any push/pop in that cycle is discarded.
//  - Compaction:
//    - Pop port p reads entry[(head + npop_before_p) mod SIZE].
//      npop_before_p = popcount(i_pop_valid[p-1:0]).
//    - Push port q writes entry[(tail + npush_before_q) mod SIZE].
//    - Invalid ports consume no slot.
//  - o_pop_id is combinational from current state; there is no same-cycle push->pop bypass.
//  - o_pop_ready = (o_count >= popcount(i_pop_valid)). It is 1 when no pop is requested.
//  - Pop accept = |i_pop_valid & o_pop_ready.
//    - On accept, head += npop mod SIZE.
//    - If not ready, nothing is consumed and no state changes on the pop side.
//  - Push check: ovf = (count - npop_acc + npush) > SIZE. Compute at $clog2(SIZE+1)+1 bits.
//    - If ovf, the whole push group is dropped (no writes, tail unchanged).
//    - o_overflow sets the next cycle and holds until reset/flush.
//  - Otherwise tail += npush mod SIZE, and count_next = count + npush - npop_acc.
//  - Full with simultaneous pop+push: both are legal. The push writes the slots freed in the
//    same cycle; reads use pre-edge array contents.
//  - Empty with simultaneous push+pop: o_pop_ready=0, so the pop stalls. The push lands and
//    is visible next cycle.
//  - Wrap: all pointer adds are modulo SIZE (subtract SIZE on >= SIZE, no bit truncation).
//    This is correct for non-power-of-two SIZE.
//  - Push IDs are not checked for duplicates or range; that is the caller's responsibility.
//  - Latency: a pushed ID is poppable 1 cycle later. Counts and flags are registered or
//    derived from registered count.
// STRUCTURE
//  - msrh_pkg: add the ID-width function and a popcount/prefix-count function, shared with
//    other multi-port queues.
//  - Sub-module msrh_wrap_add #(SIZE): ptr + inc -> (ptr+inc) mod SIZE.
//    - Instantiated once per push/pop port offset and once each for head/tail update.
//  - Storage is a flop array (SIZE x WIDTH) with PUSH_PORTS write ports and POP_PORTS read
//    ports.
// TESTING
//  1. Reset, no traffic -> o_count=32, o_full=1, o_pop_id={1,0}, o_pop_ready=1, o_overflow=0.
//  2. Pop both ports for 16 cycles -> IDs 0..31 in order.
//     - Then o_empty=1 and o_pop_ready=0 for any request.
//     - Holding pop while empty leaves o_count=0.
//  3. From empty, push {7 on port0, 9 on port1}.
//     - Next cycle: o_count=2, o_pop_id={9,7}.
//     - Pop only port1 -> it receives 7 (compaction).
//  4. SIZE=5, PUSH=POP=2.
//     - Alternate pop2/push2 for 10 cycles -> pointers wrap through 4->0 correctly.
//     - IDs are conserved; o_count oscillates 3/5.
//  5. At full, push 1 ID with no pop -> o_overflow=1 next cycle, o_count stays 32.
//     - Pop+push same cycle at full -> no overflow, count unchanged.
//  6. Mid-traffic i_flush with push+pop asserted -> next cycle count=32, o_pop_id={1,0}.
//     - o_overflow cleared; the discarded push is not present.

Source files
------------

// File: rtl/msrh_pkg.sv
// Shared helpers for the msrh multi-port queue family.
//
// Contents:
//   id_width    - number of bits needed to index n entries (never less than 1)
//   count_below - number of set bits in vec[limit-1:0], used both as a plain
//                 popcount (limit = vector width) and as the per-port prefix
//                 count that compacts multi-port requests onto consecutive slots
package msrh_pkg;

   // Index width for an n-entry structure; a 1-entry structure still needs a 1-bit pointer.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Counts the set bits of vec strictly below bit position 'limit'.
   function automatic int unsigned count_below(input logic [63:0] vec, input int unsigned limit);
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < 64; i++) begin
         if ((i < limit) && vec[i]) begin
            cnt = cnt + 1;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/msrh_wrap_add.sv
// Modulo-SIZE pointer adder.
//
// Computes (i_ptr + i_inc) mod SIZE with a single conditional subtract, which is
// exact as long as i_ptr < SIZE and i_inc <= SIZE. Works for any SIZE, including
// non-power-of-two depths where plain bit truncation would be wrong.
//
// Ports:
//   i_ptr  in   PW bits   current pointer, 0 .. SIZE-1
//   i_inc  in   CW bits   increment, 0 .. SIZE
//   o_ptr  out  PW bits   wrapped result, 0 .. SIZE-1
module msrh_wrap_add
   import msrh_pkg::*;
#(
   parameter  int SIZE = 32,
   localparam int PW   = id_width(SIZE),
   localparam int CW   = $clog2(SIZE + 1)
) (
   input  logic [PW-1:0] i_ptr,
   input  logic [CW-1:0] i_inc,
   output logic [PW-1:0] o_ptr
);

   // One extra bit holds any sum up to 2*SIZE-1 without loss.
   localparam int SW = PW + 1;

   logic [SW-1:0] sum;

   always_comb begin
      sum = SW'(i_ptr) + SW'(i_inc);
      if (sum >= SW'(SIZE)) begin
         o_ptr = PW'(sum - SW'(SIZE));
      end else begin
         o_ptr = PW'(sum);
      end
   end

endmodule

// File: rtl/msrh_freelist_mp.sv
// Multi-port circular free-ID list for rename/tag allocation.
//
// Holds up to SIZE free IDs. Up to PUSH_PORTS IDs are released and POP_PORTS IDs
// allocated each cycle; active ports are compacted onto consecutive slots. A pop
// group is all-or-nothing, a push group that would exceed SIZE is dropped and
// raises a sticky overflow flag. Reset and flush both reload entry i with INIT+i.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_flush           restore the full initial ID set (push/pop that cycle ignored)
//   i_push_valid/id   per-port release strobe and released ID
//   i_pop_valid       per-port allocation request
//   o_pop_ready       enough IDs held to serve every requested pop port
//   o_pop_id          ID offered to each pop port (from current state, no bypass)
//   o_count           number of free IDs held
//   o_empty/o_full    o_count == 0 / o_count == SIZE
//   o_overflow        sticky: a push group would have exceeded SIZE
module msrh_freelist_mp
   import msrh_pkg::*;
#(
   parameter int SIZE       = 32,
   parameter int WIDTH      = 5,
   parameter int INIT       = 0,
   parameter int PUSH_PORTS = 2,
   parameter int POP_PORTS  = 2
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_flush,
   input  logic [PUSH_PORTS-1:0]           i_push_valid,
   input  logic [PUSH_PORTS*WIDTH-1:0]     i_push_id,
   input  logic [POP_PORTS-1:0]            i_pop_valid,
   output logic                            o_pop_ready,
   output logic [POP_PORTS*WIDTH-1:0]      o_pop_id,
   output logic [$clog2(SIZE+1)-1:0]       o_count,
   output logic                            o_empty,
   output logic                            o_full,
   output logic                            o_overflow
);

   localparam int PW = id_width(SIZE);
   localparam int CW = $clog2(SIZE + 1);
   localparam int XW = CW + 1;

   logic [WIDTH-1:0] entry_q [SIZE];
   logic [WIDTH-1:0] entry_d [SIZE];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;

   logic [CW-1:0]    npop, npush, npop_acc, npush_acc;
   logic [CW-1:0]    pop_off  [POP_PORTS];
   logic [CW-1:0]    push_off [PUSH_PORTS];
   logic [PW-1:0]    rd_idx   [POP_PORTS];
   logic [PW-1:0]    wr_idx   [PUSH_PORTS];
   logic [PW-1:0]    head_next, tail_next;
   logic [XW-1:0]    level_after;
   logic             pop_ready, pop_acc, push_ovf;

   // Per-port slot offsets. A requesting port takes the slot after all lower
   // requesting ports. A non-requesting port is shown head+p so that an idle
   // list presents INIT, INIT+1, ... across the ports.
   always_comb begin
      npop  = CW'(count_below(64'(i_pop_valid), POP_PORTS));
      npush = CW'(count_below(64'(i_push_valid), PUSH_PORTS));
      for (int p = 0; p < POP_PORTS; p++) begin
         pop_off[p] = i_pop_valid[p] ? CW'(count_below(64'(i_pop_valid), unsigned'(p))) : CW'(p);
      end
      for (int q = 0; q < PUSH_PORTS; q++) begin
         push_off[q] = CW'(count_below(64'(i_push_valid), unsigned'(q)));
      end
   end

   for (genvar gp = 0; gp < POP_PORTS; gp++) begin : g_rd
      msrh_wrap_add #(.SIZE(SIZE)) u_rd_add (
         .i_ptr (head_q),
         .i_inc (pop_off[gp]),
         .o_ptr (rd_idx[gp])
      );
   end

   for (genvar gq = 0; gq < PUSH_PORTS; gq++) begin : g_wr
      msrh_wrap_add #(.SIZE(SIZE)) u_wr_add (
         .i_ptr (tail_q),
         .i_inc (push_off[gq]),
         .o_ptr (wr_idx[gq])
      );
   end

   msrh_wrap_add #(.SIZE(SIZE)) u_head_add (
      .i_ptr (head_q),
      .i_inc (npop_acc),
      .o_ptr (head_next)
   );

   msrh_wrap_add #(.SIZE(SIZE)) u_tail_add (
      .i_ptr (tail_q),
      .i_inc (npush_acc),
      .o_ptr (tail_next)
   );

   // Accept/overflow decisions. The push check uses the post-pop level so a
   // full list can pop and push in the same cycle; the extra bit keeps
   // count + npush from wrapping.
   always_comb begin
      pop_ready   = (count_q >= npop);
      pop_acc     = (|i_pop_valid) && pop_ready;
      npop_acc    = pop_acc ? npop : '0;
      level_after = XW'(count_q) - XW'(npop_acc) + XW'(npush);
      push_ovf    = (level_after > XW'(SIZE));
      npush_acc   = push_ovf ? '0 : npush;
   end

   // Next-state: pointer/count advance and compacted writes. Reads always use
   // entry_q, so a push landing on a slot popped this cycle is safe.
   always_comb begin
      head_d     = head_next;
      tail_d     = tail_next;
      count_d    = count_q - npop_acc + npush_acc;
      overflow_d = overflow_q | push_ovf;
      entry_d    = entry_q;
      for (int q = 0; q < PUSH_PORTS; q++) begin
         if (i_push_valid[q] && !push_ovf) begin
            entry_d[wr_idx[q]] = i_push_id[q*WIDTH +: WIDTH];
         end
      end
   end

   // State registers; flush behaves exactly like reset and discards that cycle's traffic.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= CW'(SIZE);
         overflow_q <= 1'b0;
         for (int i = 0; i < SIZE; i++) begin
            entry_q[i] <= WIDTH'(INIT + i);
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         entry_q    <= entry_d;
      end
   end

   always_comb begin
      o_pop_id = '0;
      for (int p = 0; p < POP_PORTS; p++) begin
         o_pop_id[p*WIDTH +: WIDTH] = entry_q[rd_idx[p]];
      end
      o_pop_ready = pop_ready;
      o_count     = count_q;
      o_empty     = (count_q == '0);
      o_full      = (count_q == CW'(SIZE));
      o_overflow  = overflow_q;
   end

endmodule

// File: tb/tb_msrh_freelist_mp.sv
// Directed testbench for msrh_freelist_mp.
// Instance A: SIZE=32, WIDTH=5 (drain, compaction, overflow, flush, full/empty corners).
// Instance B: SIZE=5, WIDTH=3 (non-power-of-two pointer wrap with ID conservation).
module tb_msrh_freelist_mp;

   logic        clock = 1'b0;
   logic        reset;

   logic        flushA;
   logic [1:0]  pushValidA;
   logic [9:0]  pushIdA;
   logic [1:0]  popValidA;
   logic        popReadyA;
   logic [9:0]  popIdA;
   logic [5:0]  countA;
   logic        emptyA, fullA, overflowA;

   logic        flushB;
   logic [1:0]  pushValidB;
   logic [5:0]  pushIdB;
   logic [1:0]  popValidB;
   logic        popReadyB;
   logic [5:0]  popIdB;
   logic [2:0]  countB;
   logic        emptyB, fullB, overflowB;

   int          numChecks = 0;
   int          numFails  = 0;

   always #5 clock = ~clock;

   msrh_freelist_mp #(.SIZE(32), .WIDTH(5), .INIT(0), .PUSH_PORTS(2), .POP_PORTS(2)) dutA (
      .i_clk        (clock),
      .i_reset      (reset),
      .i_flush      (flushA),
      .i_push_valid (pushValidA),
      .i_push_id    (pushIdA),
      .i_pop_valid  (popValidA),
      .o_pop_ready  (popReadyA),
      .o_pop_id     (popIdA),
      .o_count      (countA),
      .o_empty      (emptyA),
      .o_full       (fullA),
      .o_overflow   (overflowA)
   );

   msrh_freelist_mp #(.SIZE(5), .WIDTH(3), .INIT(0), .PUSH_PORTS(2), .POP_PORTS(2)) dutB (
      .i_clk        (clock),
      .i_reset      (reset),
      .i_flush      (flushB),
      .i_push_valid (pushValidB),
      .i_push_id    (pushIdB),
      .i_pop_valid  (popValidB),
      .o_pop_ready  (popReadyB),
      .o_pop_id     (popIdB),
      .o_count      (countB),
      .o_empty      (emptyB),
      .o_full       (fullB),
      .o_overflow   (overflowB)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives instance A inputs and lets combinational outputs settle.
   task automatic applyStimulus(input logic flush, input logic [1:0] pushValid,
                                input logic [4:0] id0, input logic [4:0] id1,
                                input logic [1:0] popValid);
      flushA     = flush;
      pushValidA = pushValid;
      pushIdA    = {id1, id0};
      popValidA  = popValid;
      #1;
   endtask

   task automatic applyStimulusB(input logic [1:0] pushValid, input logic [2:0] id0,
                                 input logic [2:0] id1, input logic [1:0] popValid);
      flushB     = 1'b0;
      pushValidB = pushValid;
      pushIdB    = {id1, id0};
      popValidB  = popValid;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      stepClock();
      stepClock();
      reset = 1'b0;
   endtask

   // Stimulus sequence; every expected value below is hand-derived.
   initial begin
      int q[$];
      int a0, a1;

      reset = 1'b1;
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      applyStimulusB(2'b00, 3'd0, 3'd0, 2'b00);
      doReset();

      $display("[TB] reset state");
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("rst_count", 32'(countA), 32);
      checkOutput("rst_full", 32'(fullA), 1);
      checkOutput("rst_empty", 32'(emptyA), 0);
      checkOutput("rst_id0", 32'(popIdA[4:0]), 0);
      checkOutput("rst_id1", 32'(popIdA[9:5]), 1);
      checkOutput("rst_ready", 32'(popReadyA), 1);
      checkOutput("rst_ovf", 32'(overflowA), 0);

      $display("[TB] drain with two pops per cycle");
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b11);
         checkOutput("drain_id0", 32'(popIdA[4:0]), 32'(2 * k));
         checkOutput("drain_id1", 32'(popIdA[9:5]), 32'(2 * k + 1));
         checkOutput("drain_ready", 32'(popReadyA), 1);
         stepClock();
      end
      checkOutput("drain_count", 32'(countA), 0);
      checkOutput("drain_empty", 32'(emptyA), 1);
      checkOutput("empty_ready2", 32'(popReadyA), 0);
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b01);
      checkOutput("empty_ready1", 32'(popReadyA), 0);
      stepClock();
      stepClock();
      checkOutput("empty_hold_count", 32'(countA), 0);

      $display("[TB] push from empty and compaction");
      applyStimulus(1'b0, 2'b11, 5'd7, 5'd9, 2'b00);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("push_count", 32'(countA), 2);
      checkOutput("push_id0", 32'(popIdA[4:0]), 7);
      checkOutput("push_id1", 32'(popIdA[9:5]), 9);
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b10);
      checkOutput("compact_ready", 32'(popReadyA), 1);
      checkOutput("compact_id1", 32'(popIdA[9:5]), 7);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("compact_count", 32'(countA), 1);
      checkOutput("compact_next", 32'(popIdA[4:0]), 9);

      $display("[TB] overflow at full");
      doReset();
      applyStimulus(1'b0, 2'b01, 5'd5, 5'd0, 2'b00);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("ovf_flag", 32'(overflowA), 1);
      checkOutput("ovf_count", 32'(countA), 32);
      checkOutput("ovf_dropped", 32'(popIdA[4:0]), 0);
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b11);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("ovf_sticky", 32'(overflowA), 1);
      checkOutput("ovf_pop_count", 32'(countA), 30);

      $display("[TB] flush with traffic");
      applyStimulus(1'b1, 2'b01, 5'd30, 5'd0, 2'b11);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("flush_count", 32'(countA), 32);
      checkOutput("flush_full", 32'(fullA), 1);
      checkOutput("flush_ovf", 32'(overflowA), 0);
      checkOutput("flush_id0", 32'(popIdA[4:0]), 0);
      checkOutput("flush_id1", 32'(popIdA[9:5]), 1);

      $display("[TB] pop and push together at full");
      applyStimulus(1'b0, 2'b11, 5'd20, 5'd21, 2'b11);
      checkOutput("fullpp_ready", 32'(popReadyA), 1);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("fullpp_count", 32'(countA), 32);
      checkOutput("fullpp_ovf", 32'(overflowA), 0);
      checkOutput("fullpp_id0", 32'(popIdA[4:0]), 2);
      checkOutput("fullpp_id1", 32'(popIdA[9:5]), 3);
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b11);
         stepClock();
      end
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("wrap_count", 32'(countA), 2);
      checkOutput("wrap_id0", 32'(popIdA[4:0]), 20);
      checkOutput("wrap_id1", 32'(popIdA[9:5]), 21);

      $display("[TB] push and pop together at empty");
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b11);
      stepClock();
      applyStimulus(1'b0, 2'b11, 5'd11, 5'd12, 2'b11);
      checkOutput("emptypp_ready", 32'(popReadyA), 0);
      stepClock();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 2'b00);
      checkOutput("emptypp_count", 32'(countA), 2);
      checkOutput("emptypp_id0", 32'(popIdA[4:0]), 11);
      checkOutput("emptypp_id1", 32'(popIdA[9:5]), 12);

      $display("[TB] SIZE=5 wrap and ID conservation");
      q = {0, 1, 2, 3, 4};
      a0 = 0;
      a1 = 0;
      for (int c = 0; c < 10; c++) begin
         if ((c % 2) == 0) begin
            applyStimulusB(2'b00, 3'd0, 3'd0, 2'b11);
            checkOutput("b_pop_id0", 32'(popIdB[2:0]), 32'(q[0]));
            checkOutput("b_pop_id1", 32'(popIdB[5:3]), 32'(q[1]));
            a0 = q.pop_front();
            a1 = q.pop_front();
            stepClock();
            applyStimulusB(2'b00, 3'd0, 3'd0, 2'b00);
            checkOutput("b_count_low", 32'(countB), 3);
         end else begin
            applyStimulusB(2'b11, 3'(a0), 3'(a1), 2'b00);
            q.push_back(a0);
            q.push_back(a1);
            stepClock();
            applyStimulusB(2'b00, 3'd0, 3'd0, 2'b00);
            checkOutput("b_count_high", 32'(countB), 5);
         end
      end
      checkOutput("b_final_id0", 32'(popIdB[2:0]), 0);
      checkOutput("b_final_id1", 32'(popIdB[5:3]), 1);
      checkOutput("b_ovf", 32'(overflowB), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
